// File: rtl/uart_tx_frame.sv
// UART frame serializer: start, DATA_WIDTH bits LSB-first, optional parity, stop; each bit held Prescale clocks (0 means 1).
// busy=1 from acceptance to the last stop edge, and Data_Valid is ignored meanwhile; define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx_frame #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      TX_OUT,
   output logic                      busy
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [PRESCALE_WIDTH-1:0] r_cnt;
   logic [PRESCALE_WIDTH-1:0] w_cnt_nxt;
   logic [PRESCALE_WIDTH-1:0] r_presc;
   logic [PRESCALE_WIDTH-1:0] w_p_last;
   logic [BIT_W-1:0]          r_bit;
   logic [BIT_W-1:0]          w_bit_nxt;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic [DATA_WIDTH-1:0]     w_shift_nxt;
   logic                      r_par_en;
   logic                      r_par_bit;
   logic                      r_tx;
   logic                      w_tx_nxt;
   logic                      r_busy;
   logic                      w_busy_nxt;
   logic                      w_accept;
   logic                      w_bit_done;

   // Last count of a bit period; a latched Prescale of 0 behaves as 1.
   assign w_p_last   = (r_presc == '0) ? '0 : r_presc - PRESCALE_WIDTH'(1);
   assign w_bit_done = (r_cnt == w_p_last);
   assign w_accept   = (r_state == S_IDLE) && Data_Valid;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_presc   <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
         if (w_accept) begin
            r_presc   <= Prescale;
            r_par_en  <= PAR_EN;
            r_par_bit <= (^P_DATA) ^ PAR_TYP;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_busy_nxt  = r_busy;
      if (r_state == S_IDLE) begin
         w_tx_nxt   = 1'b1;
         w_busy_nxt = 1'b0;
         if (Data_Valid) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = P_DATA;
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
         end
      end else if (!w_bit_done) begin
         w_cnt_nxt = r_cnt + PRESCALE_WIDTH'(1);
      end else begin
         // Next bit's level is computed here so TX_OUT comes straight from r_tx.
         w_cnt_nxt = '0;
         case (r_state)
            S_START: begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
               w_tx_nxt    = r_shift[0];
            end
            S_DATA: begin
               if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                  w_bit_nxt = '0;
                  if (r_par_en) begin
                     w_state_nxt = S_PARITY;
                     w_tx_nxt    = r_par_bit;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_bit_nxt   = r_bit + BIT_W'(1);
                  w_shift_nxt = r_shift >> 1;
                  w_tx_nxt    = w_shift_nxt[0];
               end
            end
            S_PARITY: begin
               w_state_nxt = S_STOP;
               w_bit_nxt   = '0;
               w_tx_nxt    = 1'b1;
            end
            S_STOP: begin
               w_tx_nxt = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
               if (r_bit == '0) begin
                  w_bit_nxt = BIT_W'(1);
               end else begin
                  w_state_nxt = S_IDLE;
                  w_bit_nxt   = '0;
                  w_busy_nxt  = 1'b0;
               end
`else
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
`endif
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_tx_nxt    = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT = r_tx;
   assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame against a bit-list frame model, checked every clock.
module tb_uart_tx_frame;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       busy;

`ifdef UART_TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   int n_chk = 0;
   int n_bad = 0;

   uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Offers one byte in IDLE and checks every clock of the frame plus the first idle clock.
   task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps, input bit hold, input logic [7:0] hold_d);
      bit q[$];
      int p;
      int len;
      p = (ps == 6'd0) ? 1 : int'(ps);
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (pe) q.push_back((($countones(d) % 2) == 1) ^ pt);
      for (int i = 0; i < NSTOP; i++) q.push_back(1'b1);
      len = q.size() * p;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Prescale   = ps;
      Data_Valid = 1'b1;
      @(posedge CLK); #1;
      for (int k = 0; k < len; k++) begin
         chk("tx", 32'(TX_OUT), 32'(q[k / p]));
         chk("busy", 32'(busy), 32'd1);
         if (hold) begin
            Data_Valid = 1'b1;
            P_DATA     = hold_d;
         end else begin
            Data_Valid = 1'($urandom);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            Prescale   = 6'($urandom);
         end
         @(posedge CLK); #1;
      end
      chk("end_tx", 32'(TX_OUT), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      Data_Valid = 1'b0;
   endtask

   task automatic idle_clocks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         chk("idle_tx", 32'(TX_OUT), 32'd1);
         chk("idle_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      RST        = 1'b1;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tx", 32'(TX_OUT), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      RST = 1'b0;
      idle_clocks(2);

      run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 8'h00);
      idle_clocks(2);
      run_frame(8'h07, 1'b1, 1'b0, 6'd4, 1'b0, 8'h00);
      run_frame(8'h07, 1'b1, 1'b1, 6'd4, 1'b0, 8'h00);
      run_frame(8'h03, 1'b1, 1'b0, 6'd4, 1'b0, 8'h00);
      idle_clocks(1);

      // Data_Valid held: second byte presented mid-frame, accepted after one idle clock.
      run_frame(8'h55, 1'b0, 1'b0, 6'd3, 1'b1, 8'hAA);
      run_frame(8'hAA, 1'b0, 1'b0, 6'd3, 1'b1, 8'h55);
      idle_clocks(2);

      run_frame(8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00);
      idle_clocks(1);

      // Reset during data bit 2 of a Prescale=8 frame.
      P_DATA     = 8'hC3;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd8;
      Data_Valid = 1'b1;
      @(posedge CLK); #1;
      Data_Valid = 1'b0;
      repeat (25) @(posedge CLK);
      #1;
      chk("pre_rst_tx", 32'(TX_OUT), 32'd0);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("mid_rst_tx", 32'(TX_OUT), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      RST = 1'b0;
      idle_clocks(1);
      run_frame(8'h96, 1'b1, 1'b1, 6'd8, 1'b0, 8'h00);

      run_frame(8'hE1, 1'b1, 1'b0, 6'd8, 1'b0, 8'h00);

      for (int f = 0; f < 40; f++) begin
         run_frame(8'($urandom), 1'($urandom), 1'($urandom),
                   6'($urandom_range(10, 0)), 1'b0, 8'h00);
         idle_clocks(int'($urandom_range(2, 0)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
